// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
// Op codes match the decoder's 3-bit mdu op field.
package mdu_pkg;

   localparam logic [2:0] MDU_NOP   = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing HI/LO results.
// Division by zero and signed overflow yield fixed, defined values.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   dvd;
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   r;
   logic [WIDTH-1:0]   sq;
   logic [WIDTH-1:0]   sr;
   logic               neg_a;
   logic               neg_b;
   logic               zero_b;
   logic               ovf;
   logic               sgn;

   assign prod_s = {{WIDTH{srca[WIDTH-1]}}, srca}
                 * {{WIDTH{srcb[WIDTH-1]}}, srcb};
   assign prod_u = {{WIDTH{1'b0}}, srca} * {{WIDTH{1'b0}}, srcb};

   // Signed divide runs on magnitudes through the same unsigned divider
   assign neg_a  = srca[WIDTH-1];
   assign neg_b  = srcb[WIDTH-1];
   assign abs_a  = neg_a ? (~srca + 1'b1) : srca;
   assign abs_b  = neg_b ? (~srcb + 1'b1) : srcb;
   assign sgn    = (op == MDU_DIV);
   assign zero_b = (srcb == '0);
   assign ovf    = (srca == MOST_NEG) && (srcb == '1);

   assign dvd = sgn ? abs_a : srca;
   assign dvs = zero_b ? ONE : (sgn ? abs_b : srcb);
   assign q   = dvd / dvs;
   assign r   = dvd % dvs;
   assign sq  = (neg_a ^ neg_b) ? (~q + 1'b1) : q;
   assign sr  = neg_a ? (~r + 1'b1) : r;

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      unique case (op)
         MDU_MULT: begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
         end
         MDU_MULTU: begin
            res_hi = prod_u[2*WIDTH-1:WIDTH];
            res_lo = prod_u[WIDTH-1:0];
         end
         MDU_DIV: begin
            if (zero_b) begin
               res_hi = srca;
               res_lo = '1;
            end else if (ovf) begin
               res_hi = '0;
               res_lo = MOST_NEG;
            end else begin
               res_hi = sr;
               res_lo = sq;
            end
         end
         MDU_DIVU: begin
            if (zero_b) begin
               res_hi = srca;
               res_lo = '1;
            end else begin
               res_hi = r;
               res_lo = q;
            end
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at start and held pending until the latency expires.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT) + 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             is_mul;
   logic             is_md;
   logic             load;
   logic             commit;
   logic             wr_hi;
   logic             wr_lo;

   mdu_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .op     (op),
      .srca   (srca),
      .srcb   (srcb),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
   assign is_md  = is_mul || (op == MDU_DIV) || (op == MDU_DIVU);
   assign busy   = (state == ST_RUN);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      commit   = 1'b0;
      wr_hi    = 1'b0;
      wr_lo    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               unique case (1'b1)
                  is_md: begin
                     load     = 1'b1;
                     state_nx = ST_RUN;
                     cnt_nx   = is_mul ? MUL_LOAD : DIV_LOAD;
                  end
                  (op == MDU_MTHI): wr_hi = 1'b1;
                  (op == MDU_MTLO): wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Starts are dropped here; the pipeline stalls on busy
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else begin
               commit   = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         done  <= commit;
         if (load) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
         end
         if (commit) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end else begin
            if (wr_hi) hi <= srca;
            if (wr_lo) lo <= srca;
         end
      end
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Parametrised multi-cycle multiply/divide unit that succeeds the single-cycle combinational ALU. It owns the architectural HI/LO registers for the pipelined MIPS core and sits beside the ALU in the EX stage. It accepts one operation per start pulse and holds busy for a configurable latency. The pipeline stalls on busy and reads hi/lo directly.

Parameters:
WIDTH, 32, operand and HI/LO width (>=2)
MUL_LAT, 5, cycles busy is held for MULT/MULTU (>=1)
DIV_LAT, 10, cycles busy is held for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request strobe; op/srca/srcb are sampled with it
op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
srca  input  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO data)
srcb  input  WIDTH  operand B (divisor / multiplier)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high while a MULT/DIV operation is in flight
done  output  1  one-cycle pulse in the cycle after HI/LO commit

Behaviour:
- Reset: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, pending results cleared. Reset acts immediately, not on a clock edge.
- FSM states: IDLE and RUN.
- IDLE, start with op 1-4 at edge T:
  - Compute the result and latch it into pending_hi/pending_lo.
  - Load counter = LAT-1, where LAT is MUL_LAT or DIV_LAT.
  - Go to RUN. busy=1 from T+1.
- RUN, each edge:
  - If counter != 0: decrement.
  - If counter == 0: hi<=pending_hi, lo<=pending_lo, go to IDLE, busy<=0, done<=1 for one cycle.
  - busy is therefore high for exactly LAT cycles. hi/lo hold their old values until the commit edge (edge T+LAT).
- MTHI/MTLO with start in IDLE: hi (or lo) <= srca at the next edge. busy stays 0 and done stays 0.
- start while busy=1 (any op, including MTHI/MTLO) is ignored and has no side effects. The core must stall instead.
- NOP/reserved op with start: no effect.
- Arithmetic:
  - MULT: signed full 2*WIDTH-bit product, hi = upper half, lo = lower half.
  - MULTU: same, unsigned.
  - DIV: signed, quotient truncated toward zero into lo; remainder into hi, with the sign of the dividend.
  - DIVU: unsigned quotient into lo, remainder into hi.
- Division boundary cases (decided; not left undefined):
  - Divide by zero, signed or unsigned: lo = all ones, hi = srca.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- done and start in the same cycle: the new start is accepted normally. done is independent of the new operation.
- reset asserted mid-RUN: the in-flight operation is discarded, no done is emitted, and hi/lo return to 0.
- Counter width = clog2(max(MUL_LAT, DIV_LAT)) + 1.

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding constants: MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO;
  - state encoding: ST_IDLE, ST_RUN.
- One sub-module, mdu_calc: purely combinational. Takes op, srca, srcb and produces res_hi, res_lo, including the divide-by-zero and overflow rules.
- The top level holds the FSM, counter, pending registers and HI/LO.

Test Plan:
(WIDTH=32, MUL_LAT=5, DIV_LAT=10)
1. MULT 0xFFFFFFFE x 3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
2. DIV 0xFFFFFFF9 (-7) / 2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
3. DIV 5 / 0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, busy=0, done=0. Then, during a MULT, MTLO 0x55 and a second MULT -> both ignored; lo shows only the first MULT's result.
5. Start DIV, assert reset in cycle 4 -> busy, hi, lo and done go to 0 at once. After reset is released, no done pulse occurs.
6. Start a MULT on the cycle done is high -> the new MULT is accepted and busy is high 5 cycles again. Check hi/lo hold the previous result until the new commit edge.
